// File: rtl/core_pkg.sv
// Shared definitions for the multicycle RV32I core: FSM state encoding,
// opcode constants, ALU operation encodings and the combinational helpers
// used by the datapath (immediate generator, control decode, ALU, branch
// compare and load extension).
package core_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_HALT    = 3'd5
    } state_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    // SYSTEM (ECALL/EBREAK) and FENCE are deliberately not legal: they halt the core.
    function automatic logic opcode_legal(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_REG: opcode_legal = 1'b1;
            default:                           opcode_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] imm_gen(input logic [31:0] ir);
        case (ir[6:0])
            OP_IMM, OP_LOAD, OP_JALR: imm_gen = {{20{ir[31]}}, ir[31:20]};
            OP_STORE:                 imm_gen = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OP_BRANCH:                imm_gen = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            OP_LUI, OP_AUIPC:         imm_gen = {ir[31:12], 12'h000};
            OP_JAL:                   imm_gen = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default:                  imm_gen = 32'h0000_0000;
        endcase
    endfunction

    // funct7[5] selects SUB only for register-register ops, SRA for both shift forms.
    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic f7b5, input logic is_reg);
        case (f3)
            3'b000:  alu_decode = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_decode = ALU_SLL;
            3'b010:  alu_decode = ALU_SLT;
            3'b011:  alu_decode = ALU_SLTU;
            3'b100:  alu_decode = ALU_XOR;
            3'b101:  alu_decode = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_decode = ALU_OR;
            3'b111:  alu_decode = ALU_AND;
            default: alu_decode = ALU_ADD;
        endcase
    endfunction

    function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_ADD:  alu = a + b;
            ALU_SUB:  alu = a - b;
            ALU_SLL:  alu = a << b[4:0];
            ALU_SLT:  alu = {31'h0, ($signed(a) < $signed(b))};
            ALU_SLTU: alu = {31'h0, (a < b)};
            ALU_XOR:  alu = a ^ b;
            ALU_SRL:  alu = a >> b[4:0];
            ALU_SRA:  alu = 32'($signed(a) >>> b[4:0]);
            ALU_OR:   alu = a | b;
            ALU_AND:  alu = a & b;
            default:  alu = 32'h0000_0000;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  branch_taken = (a == b);
            3'b001:  branch_taken = (a != b);
            3'b100:  branch_taken = ($signed(a) < $signed(b));
            3'b101:  branch_taken = ($signed(a) >= $signed(b));
            3'b110:  branch_taken = (a < b);
            3'b111:  branch_taken = (a >= b);
            default: branch_taken = 1'b0;
        endcase
    endfunction

    // Read data arrives right-aligned; narrow loads are extended here.
    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  load_ext = {{24{d[7]}}, d[7:0]};
            3'b001:  load_ext = {{16{d[15]}}, d[15:0]};
            3'b100:  load_ext = {24'h0, d[7:0]};
            3'b101:  load_ext = {16'h0, d[15:0]};
            default: load_ext = d;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_fsm.sv
// Control FSM and memory handshake of the multicycle core. Owns the state
// register, the request strobe and the mem_ready timeout watchdog.
module multicycle_fsm
    import core_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_ready,
    input  logic [6:0] opcode,
    input  logic       new_pc_bad,
    output state_e     state,
    output logic       mem_req,
    output logic       mem_done
);

    state_e      state_r;
    state_e      next_state_s;
    logic [31:0] wait_cnt_r;
    logic        req_phase_s;
    logic        timeout_s;

    // Requests are gated by reset so nothing is issued while rst is low, and the
    // first fetch is visible in the very first cycle after release.
    assign req_phase_s = (state_r == ST_FETCH) || (state_r == ST_MEM);
    assign mem_req     = req_phase_s & rst;
    assign mem_done    = mem_req & mem_ready;
    assign timeout_s   = (MAX_WAIT != 32'd0) && req_phase_s && !mem_ready &&
                         (wait_cnt_r == (MAX_WAIT - 32'd1));
    assign state       = state_r;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Count consecutive request cycles without mem_ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt_r <= 32'd0;
        end else if (req_phase_s && !mem_ready) begin
            wait_cnt_r <= wait_cnt_r + 32'd1;
        end else begin
            wait_cnt_r <= 32'd0;
        end
    end

    // Next-state logic; illegal/system opcodes and misaligned targets halt.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (timeout_s)     next_state_s = ST_HALT;
                else if (mem_done) next_state_s = ST_DECODE;
                else               next_state_s = ST_FETCH;
            end
            ST_DECODE: begin
                if (!opcode_legal(opcode)) next_state_s = ST_HALT;
                else                       next_state_s = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (opcode == OP_BRANCH)                        next_state_s = new_pc_bad ? ST_HALT : ST_FETCH;
                else if (opcode == OP_LOAD || opcode == OP_STORE) next_state_s = ST_MEM;
                else                                            next_state_s = ST_WB;
            end
            ST_MEM: begin
                if (timeout_s)     next_state_s = ST_HALT;
                else if (mem_done) next_state_s = (opcode == OP_STORE) ? ST_FETCH : ST_WB;
                else               next_state_s = ST_MEM;
            end
            ST_WB: begin
                if (new_pc_bad) next_state_s = ST_HALT;
                else            next_state_s = ST_FETCH;
            end
            ST_HALT:  next_state_s = ST_HALT;
            default:  next_state_s = ST_HALT;
        endcase
    end

endmodule

// File: rtl/multicycle_core.sv
// Multicycle RV32I core (no FENCE/CSR): datapath, register file and PC.
// Optional performance counters are built when MULTICYCLE_PERF_CNT_EN is
// defined; otherwise cycle_cnt/instret_cnt are tied to zero.
module multicycle_core
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        halted,
    output logic [31:0] pc,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    state_e      state_s;
    logic        mem_done_s;
    logic [31:0] pc_r, ir_r, a_r, b_r, imm_r, alu_r, mdr_r;
    logic [31:0] rf_r [32];
    logic [6:0]  opcode_s;
    logic [4:0]  rd_s, rs1_s, rs2_s;
    logic [2:0]  f3_s;
    logic [31:0] rs1_val_s, rs2_val_s, pc_plus4_s;
    logic [31:0] alu_b_s, exe_result_s, branch_pc_s, wb_pc_s, wb_data_s;
    alu_op_e     alu_op_s;
    logic        link_s, new_pc_bad_s;

    assign opcode_s   = ir_r[6:0];
    assign rd_s       = ir_r[11:7];
    assign f3_s       = ir_r[14:12];
    assign rs1_s      = ir_r[19:15];
    assign rs2_s      = ir_r[24:20];
    assign rs1_val_s  = (rs1_s == 5'd0) ? 32'h0 : rf_r[rs1_s];
    assign rs2_val_s  = (rs2_s == 5'd0) ? 32'h0 : rf_r[rs2_s];
    assign pc_plus4_s = pc_r + 32'd4;
    assign link_s     = (opcode_s == OP_JAL) || (opcode_s == OP_JALR);

    multicycle_fsm #(.MAX_WAIT(MAX_WAIT)) u_fsm (
        .clk        (clk),
        .rst        (rst),
        .mem_ready  (mem_ready),
        .opcode     (opcode_s),
        .new_pc_bad (new_pc_bad_s),
        .state      (state_s),
        .mem_req    (mem_req),
        .mem_done   (mem_done_s)
    );

    // Execute-stage result, branch target and write-back selection.
    always_comb begin
        alu_op_s     = alu_decode(f3_s, ir_r[30], (opcode_s == OP_REG));
        alu_b_s      = (opcode_s == OP_REG) ? b_r : imm_r;
        exe_result_s = 32'h0;
        case (opcode_s)
            OP_LUI:             exe_result_s = imm_r;
            OP_AUIPC, OP_JAL:   exe_result_s = pc_r + imm_r;
            OP_JALR:            exe_result_s = (a_r + imm_r) & 32'hFFFF_FFFE;
            OP_LOAD, OP_STORE:  exe_result_s = a_r + imm_r;
            default:            exe_result_s = alu(alu_op_s, a_r, alu_b_s);
        endcase
        branch_pc_s = branch_taken(f3_s, a_r, b_r) ? (pc_r + imm_r) : pc_plus4_s;
        wb_pc_s     = link_s ? alu_r : pc_plus4_s;
        if (link_s)                     wb_data_s = pc_plus4_s;
        else if (opcode_s == OP_LOAD)   wb_data_s = mdr_r;
        else                            wb_data_s = alu_r;
        if (state_s == ST_EXECUTE)      new_pc_bad_s = branch_pc_s[1];
        else                            new_pc_bad_s = wb_pc_s[1];
    end

    // Datapath registers and PC, advanced according to the FSM state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_r  <= RESET_PC;
            ir_r  <= 32'h0;
            a_r   <= 32'h0;
            b_r   <= 32'h0;
            imm_r <= 32'h0;
            alu_r <= 32'h0;
            mdr_r <= 32'h0;
        end else begin
            case (state_s)
                ST_FETCH:   if (mem_done_s) ir_r <= mem_rdata;
                ST_DECODE: begin
                    a_r   <= rs1_val_s;
                    b_r   <= rs2_val_s;
                    imm_r <= imm_gen(ir_r);
                end
                ST_EXECUTE: begin
                    alu_r <= exe_result_s;
                    if (opcode_s == OP_BRANCH && !branch_pc_s[1]) pc_r <= branch_pc_s;
                end
                ST_MEM: begin
                    if (mem_done_s) begin
                        if (opcode_s == OP_STORE) pc_r  <= pc_plus4_s;
                        else                      mdr_r <= load_ext(f3_s, mem_rdata);
                    end
                end
                ST_WB:      if (!wb_pc_s[1]) pc_r <= wb_pc_s;
                default:    ;
            endcase
        end
    end

    // Register file; x0 is never written and always reads back as zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rf_r[i] <= 32'h0;
        end else if (state_s == ST_WB && !wb_pc_s[1] && rd_s != 5'd0) begin
            rf_r[rd_s] <= wb_data_s;
        end
    end

    assign mem_we     = (state_s == ST_MEM) && (opcode_s == OP_STORE);
    assign mem_addr   = (state_s == ST_MEM) ? alu_r : pc_r;
    assign mem_wdata  = b_r;
    assign mem_funct3 = (state_s == ST_MEM) ? f3_s : 3'b010;
    assign halted     = (state_s == ST_HALT);
    assign pc         = pc_r;

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cycle_cnt_r, instret_cnt_r;
    logic        retire_s;

    assign retire_s = ((state_s == ST_EXECUTE) && (opcode_s == OP_BRANCH) && !branch_pc_s[1]) ||
                      ((state_s == ST_MEM) && mem_done_s && (opcode_s == OP_STORE)) ||
                      ((state_s == ST_WB) && !wb_pc_s[1]);

    // Free-running cycle and retired-instruction counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_cnt_r   <= 32'h0;
            instret_cnt_r <= 32'h0;
        end else begin
            if (state_s != ST_HALT) cycle_cnt_r   <= cycle_cnt_r + 32'd1;
            if (retire_s)           instret_cnt_r <= instret_cnt_r + 32'd1;
        end
    end

    assign cycle_cnt   = cycle_cnt_r;
    assign instret_cnt = instret_cnt_r;
`else
    assign cycle_cnt   = 32'h0;
    assign instret_cnt = 32'h0;
`endif

endmodule

// File: doc/multicycle_core.md
MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded by reset.
REQ-002 SHALL have parameter MAX_WAIT, default 0 (0 = unlimited), number of mem_ready wait cycles before the core halts on timeout.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port mem_req  out  1  memory access request.
REQ-006 SHALL have port mem_we  out  1  1 = store, 0 = fetch or load.
REQ-007 SHALL have port mem_addr  out  32  byte address of the access.
REQ-008 SHALL have port mem_wdata  out  32  store data, the rs2 value.
REQ-009 SHALL have port mem_funct3  out  3  access size/sign; 3'b010 for fetches.
REQ-010 SHALL have port mem_rdata  in  32  read data, valid when mem_ready=1.
REQ-011 SHALL have port mem_ready  in  1  access completes this cycle.
REQ-012 SHALL have port halted  out  1  core stopped.
REQ-013 SHALL have port pc  out  32  current PC.
REQ-014 SHALL have ports cycle_cnt and instret_cnt  out  32 each  performance counters.

Function
REQ-015 SHALL implement RV32I (minus FENCE/CSR) as an FSM with states FETCH, DECODE, EXECUTE, MEM, WB, HALT.
REQ-016 FETCH SHALL drive mem_req=1, mem_we=0, mem_addr=pc, and latch mem_rdata into the instruction register on mem_ready=1, then go to DECODE.
REQ-017 DECODE SHALL latch rs1/rs2 values and the immediate into internal A/B/IMM registers.
REQ-018 EXECUTE SHALL latch the ALU result and resolve branches. Branch: PC<=taken?pc+imm:pc+4, then FETCH. Load/store: go to MEM. Others: go to WB.
REQ-019 MEM SHALL drive mem_req=1, mem_addr=ALU result, and mem_we=1 for stores. On mem_ready: a load latches mem_rdata and goes to WB; a store sets PC<=pc+4 and goes to FETCH.
REQ-020 WB SHALL write rd (ALU result, load data, or pc+4 for JAL/JALR), update PC (pc+4, pc+imm for JAL, (rs1+imm)&~1 for JALR), and go to FETCH.
REQ-021 Zero-wait CPI SHALL be: branch 3, ALU/LUI/AUIPC/JAL/JALR/store 4, load 5; each wait cycle adds one.
REQ-022 mem_req with mem_addr/mem_we/mem_wdata/mem_funct3 SHALL be held stable until the mem_ready=1 cycle. mem_req SHALL drop the following cycle. mem_ready SHALL be ignored while mem_req=0.
REQ-023 Writes to x0 SHALL be discarded; x0 SHALL read 0.
REQ-024 ECALL/EBREAK (opcode 7'b1110011), an illegal opcode, or a new PC with bit1 set SHALL enter HALT instead of updating PC.
REQ-025 HALT SHALL be absorbing until reset: halted=1, mem_req=0, PC frozen.
REQ-026 With MAX_WAIT>0, mem_ready low for MAX_WAIT consecutive request cycles SHALL enter HALT.
REQ-027 instret_cnt SHALL increment once per completed instruction. cycle_cnt SHALL increment every non-HALT cycle. Both SHALL wrap at 2^32.

Reset
REQ-028 On rst=0 at a clock edge: state<=FETCH, pc<=RESET_PC, register file cleared, counters 0, halted 0, mem_req 0.
REQ-029 Reset SHALL dominate mid-access. A pending request SHALL be abandoned, and the first request SHALL issue in the first cycle after rst=1.

Configuration
REQ-030 Macro MULTICYCLE_PERF_CNT_EN: when defined, REQ-027 counters SHALL be implemented.
REQ-031 When MULTICYCLE_PERF_CNT_EN is undefined, cycle_cnt and instret_cnt SHALL be constant 0, with no counter flops.

Structure
REQ-032 Package core_pkg SHALL hold the FSM state enum, RV32I opcode constants and ALU op encodings.
REQ-033 The datapath SHALL reuse the team's ALU, register file, immediate generator and control decoder.
REQ-034 The FSM and memory handshake SHALL live in one sub-module, multicycle_fsm.

Verification
REQ-035 Reset with RESET_PC=32'h100, zero-wait memory, then release -> first mem_req in cycle 1 with mem_addr=32'h100.
REQ-036 Program addi x1,x0,5; addi x2,x1,-2; sw x2,8(x0); lw x3,8(x0) -> store of 3 to 8, x3=3, 17 cycles, instret_cnt=4.
REQ-037 mem_ready held low 3 cycles on a fetch -> address/req stable 4 cycles, CPI +3.
REQ-038 beq x0,x0,-8 at 32'h20 -> next fetch at 32'h18 after 3 cycles. jalr x1,0(x5) with x5=32'h41 -> pc=32'h40, x1=pc+4.
REQ-039 ecall -> halted=1 next state, mem_req=0 thereafter. rst=0 -> restart at RESET_PC.
REQ-040 MAX_WAIT=4, mem_ready never asserted -> HALT after 4 request cycles. Undefined macro -> counters read 0.
